// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic-array operand feeders.
package systolic_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FEED = 1'b1
  } feed_state_t;

  // Number of skewed steps needed to push a W x L operand block through.
  function automatic int unsigned feed_steps(input int unsigned w, input int unsigned l);
    return w + l - 1;
  endfunction

  // Step counter width, at least one bit.
  function automatic int unsigned step_cnt_w(input int unsigned w, input int unsigned l);
    int unsigned s;
    s = feed_steps(w, l);
    return (s > 1) ? $clog2(s) : 1;
  endfunction

endpackage

// File: rtl/b_skew_lane.sv
// One output lane (column j of B): holds the captured column and emits B[s-j][j].
module b_skew_lane
  import systolic_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ARRAY_W    = 4,
  parameter int unsigned LANE       = 0,
  parameter int unsigned CNT_W      = 3
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  load,
  input  logic                                  advance,
  input  logic                                  clear,
  input  logic [CNT_W-1:0]                      step_next,
  input  logic [0:ARRAY_W-1][DATA_WIDTH-1:0]    col_in,
  output logic [DATA_WIDTH-1:0]                 b_out,
  output logic                                  b_valid
);

  localparam int unsigned K_W = (ARRAY_W > 1) ? $clog2(ARRAY_W) : 1;

  logic [0:ARRAY_W-1][DATA_WIDTH-1:0] col_q;
  logic [0:ARRAY_W-1][DATA_WIDTH-1:0] src_col;
  logic [CNT_W-1:0]                   src_step;
  logic [DATA_WIDTH-1:0]              nxt_data;
  logic                               nxt_valid;

  // Select the element this lane shows at the upcoming step; step 0 comes straight from data_in.
  always_comb begin
    src_col   = load ? col_in : col_q;
    src_step  = load ? '0 : step_next;
    nxt_data  = '0;
    nxt_valid = 1'b0;
    for (int unsigned k = 0; k < ARRAY_W; k++) begin
      if (src_step == CNT_W'(k + LANE)) begin
        nxt_data  = src_col[K_W'(k)];
        nxt_valid = 1'b1;
      end
    end
  end

  // Column capture and registered lane outputs; nothing moves while stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      col_q   <= '0;
      b_out   <= '0;
      b_valid <= 1'b0;
    end else if (load) begin
      col_q   <= col_in;
      b_out   <= nxt_data;
      b_valid <= nxt_valid;
    end else if (clear) begin
      b_out   <= '0;
      b_valid <= 1'b0;
    end else if (advance) begin
      b_out   <= nxt_data;
      b_valid <= nxt_valid;
    end
  end

endmodule

// File: rtl/b_skew_feeder.sv
// Captures the B matrix on start and streams it diagonally skewed into the array top edge.
module b_skew_feeder
  import systolic_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ARRAY_W    = 4,
  parameter int unsigned ARRAY_L    = 4
) (
  input  logic                                              clk,
  input  logic                                              reset,
  input  logic                                              start,
  input  logic                                              hold,
  input  logic [0:ARRAY_W-1][0:ARRAY_L-1][DATA_WIDTH-1:0]   data_in,
  output logic [0:ARRAY_L-1][DATA_WIDTH-1:0]                b_out,
  output logic [0:ARRAY_L-1]                                b_valid,
  output logic                                              busy,
  output logic                                              done
);

  localparam int unsigned STEPS = feed_steps(ARRAY_W, ARRAY_L);
  localparam int unsigned CNT_W = step_cnt_w(ARRAY_W, ARRAY_L);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

  feed_state_t      state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] step_next;
  logic             load_c;
  logic             advance_c;
  logic             clear_c;

  // Lane control decoded from the current state and handshake inputs.
  assign load_c    = (state == IDLE) && start;
  assign advance_c = (state == FEED) && !hold && (cnt != LAST_STEP);
  assign clear_c   = (state == FEED) && !hold && (cnt == LAST_STEP);
  assign step_next = cnt + CNT_W'(1);

  // Feed FSM, step counter and start/busy/done handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= FEED;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        FEED: begin
          if (!hold) begin
            if (cnt == LAST_STEP) begin
              state <= IDLE;
              cnt   <= '0;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              cnt <= step_next;
            end
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  for (genvar j = 0; j < ARRAY_L; j++) begin : g_lane
    logic [0:ARRAY_W-1][DATA_WIDTH-1:0] col;

    for (genvar k = 0; k < ARRAY_W; k++) begin : g_col
      assign col[k] = data_in[k][j];
    end

    b_skew_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .ARRAY_W    (ARRAY_W),
      .LANE       (j),
      .CNT_W      (CNT_W)
    ) u_lane (
      .clk       (clk),
      .reset     (reset),
      .load      (load_c),
      .advance   (advance_c),
      .clear     (clear_c),
      .step_next (step_next),
      .col_in    (col),
      .b_out     (b_out[j]),
      .b_valid   (b_valid[j])
    );
  end

endmodule
